// File: rtl/drfa_pkg.sv
// Shared types for the return-address stack.
// Holds the default widths and the packed stack entry.
package drfa_pkg;

  localparam int PC_W   = 9;
  localparam int FLAG_W = 4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [FLAG_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/call_stack_mem.sv
// Unreset register file behind the call stack.
// One write port, one asynchronous read port.
module stack_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 13,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware call stack saving return address and ALU flags.
// Full-stack pushes either drop or overwrite the oldest entry.
module call_stack
  import drfa_pkg::*;
#(
  parameter int PC_WIDTH   = PC_W,
  parameter int FLAG_WIDTH = FLAG_W,
  parameter int DEPTH      = 8,
  parameter int WRAP_MODE  = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_en,
  input  logic                  pop_en,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [FLAG_WIDTH-1:0] in_flags,
  input  logic                  clear_err,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [FLAG_WIDTH-1:0] out_flags,
  output logic                  out_valid,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  logic [AW-1:0] sp, sp_n, top, waddr;
  logic [CW-1:0] cnt_n;
  logic          we, ld, oe, ue;
  entry_t        wdata, rdata;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = sp - 1'b1;
  assign wdata = '{pc: in_pc, flags: in_flags};

  always_comb begin
    we    = 1'b0;
    waddr = sp;
    sp_n  = sp;
    cnt_n = count;
    ld    = 1'b0;
    oe    = 1'b0;
    ue    = 1'b0;
    if (push_en && pop_en && !empty) begin
      // swap: read old top, overwrite it in place
      we    = 1'b1;
      waddr = top;
      ld    = 1'b1;
    end else if (push_en) begin
      ue = pop_en;
      if (!full) begin
        we    = 1'b1;
        sp_n  = sp + 1'b1;
        cnt_n = count + 1'b1;
      end else begin
        oe = 1'b1;
        if (WRAP_MODE != 0) begin
          we   = 1'b1;
          sp_n = sp + 1'b1;
        end
      end
    end else if (pop_en) begin
      if (!empty) begin
        sp_n  = top;
        cnt_n = count - 1'b1;
        ld    = 1'b1;
      end else begin
        ue = 1'b1;
      end
    end
  end

  stack_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_mem (
    .clk   (clk),
    .we    (we && !rst),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      count     <= '0;
      out_pc    <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      count     <= cnt_n;
      out_valid <= ld;
      if (ld) begin
        out_pc    <= rdata.pc;
        out_flags <= rdata.flags;
      end
      overflow  <= oe | (overflow & ~clear_err);
      underflow <= ue | (underflow & ~clear_err);
    end
  end

endmodule
